// File: rtl/ram_io_responder_pkg.sv
// Shared definitions for the RAM / I/O responder: I/O window layout,
// STATUS register bit positions and the common byte type.
`ifndef RAM_IO_RESPONDER_PKG_MACROS
`define RAM_IO_RESPONDER_PKG_MACROS
`define True    1'b1
`define False   1'b0
`define ByteBus logic [7:0]
`endif

package ram_io_responder_pkg;

    typedef `ByteBus byte_t;

    // I/O window occupies 0x30000-0x3FFFF; everything else is RAM
    localparam logic [31:0] IO_BASE    = 32'h0003_0000;
    localparam logic [15:0] DATA_OFS   = 16'h0000;
    localparam logic [15:0] STATUS_OFS = 16'h0004;

    // STATUS register bit positions
    localparam int STAT_RXNE = 0;
    localparam int STAT_TXF  = 1;
    localparam int STAT_OVF  = 2;

    function automatic byte_t status_byte(input logic ovf, input logic tx_full,
                                          input logic rx_nonempty);
        byte_t s;
        s            = {8{`False}};
        s[STAT_OVF]  = ovf;
        s[STAT_TXF]  = tx_full;
        s[STAT_RXNE] = rx_nonempty;
        return s;
    endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// Byte-serial RAM bus plus the TX/RX host-link handshakes.
// IO_FULL_EN adds the io_buffer_full early-warning signal.
interface ram_io_if
    import ram_io_responder_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              ram_r_w;
    logic [ADDR_W-1:0] ram_addr;
    byte_t             ram_w_data;
    byte_t             ram_r_data;
    byte_t             io_tx_data;
    logic              io_tx_valid;
    logic              io_tx_ready;
    byte_t             io_rx_data;
    logic              io_rx_valid;
    logic              io_rx_ready;
`ifdef IO_FULL_EN
    logic              io_buffer_full;
`endif

    modport master (
        output ram_r_w, ram_addr, ram_w_data, io_tx_ready, io_rx_data, io_rx_valid,
        input  ram_r_data, io_tx_data, io_tx_valid, io_rx_ready
`ifdef IO_FULL_EN
        , input io_buffer_full
`endif
    );

    modport slave (
        input  ram_r_w, ram_addr, ram_w_data, io_tx_ready, io_rx_data, io_rx_valid,
        output ram_r_data, io_tx_data, io_tx_valid, io_rx_ready
`ifdef IO_FULL_EN
        , output io_buffer_full
`endif
    );
endinterface

// File: rtl/ram_io_responder_byte_fifo.sv
// Synchronous byte FIFO with show-ahead head. A push while full is only
// taken when a pop happens in the same cycle; a pop while empty is ignored.
module byte_fifo
    import ram_io_responder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  byte_t                    din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output byte_t                    head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    byte_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ram_io_responder.sv
// Far-end responder of the byte-serial RAM bus. Low addresses hit a
// synchronous byte RAM; the 0x30000 window maps DATA/STATUS registers onto
// buffered TX/RX byte streams. Optional macro IO_FULL_EN adds a registered
// io_buffer_full warning when the TX FIFO is two entries from full.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int RAM_ADDR_W = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    ram_io_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ADDR_W-1:0]     addr;
    logic                  io_sel;
    logic [15:0]           io_ofs;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  addr_unused;

    logic  ram_we;
    logic  data_wr;
    logic  data_rd;
    logic  stat_wr;

    byte_t                 mem [2**RAM_ADDR_W];
    byte_t                 r_data;
    byte_t                 io_rd;
    logic                  tx_overflow;

    logic                  tx_push;
    logic                  tx_pop;
    logic                  tx_full;
    logic                  tx_empty;
    logic [PTR_W:0]        tx_count;
    byte_t                 tx_head;

    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_full;
    logic                  rx_empty;
    logic [PTR_W:0]        rx_count_unused;
    byte_t                 rx_head;

    assign addr        = bus.ram_addr;
    assign io_sel      = (addr[17:16] == IO_BASE[17:16]);
    assign io_ofs      = addr[15:0];
    assign ram_idx     = addr[RAM_ADDR_W-1:0];
    assign addr_unused = ^addr[ADDR_W-1:18];

    assign ram_we  = !io_sel && bus.ram_r_w;
    assign data_wr = io_sel &&  bus.ram_r_w && (io_ofs == DATA_OFS);
    assign data_rd = io_sel && !bus.ram_r_w && (io_ofs == DATA_OFS);
    assign stat_wr = io_sel &&  bus.ram_r_w && (io_ofs == STATUS_OFS);

    // A full TX FIFO still accepts a CPU byte when the sink drains one that cycle
    assign tx_pop  = !tx_empty && bus.io_tx_ready;
    assign tx_push = data_wr && (!tx_full || tx_pop);
    assign rx_push = bus.io_rx_valid && !rx_full;
    assign rx_pop  = data_rd && !rx_empty;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (bus.ram_w_data),
        .pop   (tx_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count),
        .head  (tx_head)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (bus.io_rx_data),
        .pop   (rx_pop),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count_unused),
        .head  (rx_head)
    );

    assign bus.io_tx_valid = !tx_empty;
    assign bus.io_tx_data  = tx_head;
    assign bus.io_rx_ready = !rx_full;
    assign bus.ram_r_data  = r_data;

    // I/O register read mux
    always_comb begin
        io_rd = '0;
        if (io_ofs == DATA_OFS) begin
            io_rd = rx_empty ? '0 : rx_head;
        end else if (io_ofs == STATUS_OFS) begin
            io_rd = status_byte(tx_overflow, tx_full, !rx_empty);
        end
    end

    // RAM array write port
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= bus.ram_w_data;
        end
    end

    // Registered read data; writes leave the previous value in place
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (!bus.ram_r_w) begin
            r_data <= io_sel ? io_rd : mem[ram_idx];
        end
    end

    // Sticky TX overflow, cleared by writing STATUS with the OVF bit set
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_overflow <= 1'b0;
        end else if (data_wr && tx_full && !tx_pop) begin
            tx_overflow <= 1'b1;
        end else if (stat_wr && bus.ram_w_data[STAT_OVF]) begin
            tx_overflow <= 1'b0;
        end
    end

`ifdef IO_FULL_EN
    localparam logic [PTR_W:0] BF_THRESH = (PTR_W + 1)'(FIFO_DEPTH - 2);
    logic buffer_full;

    // Early warning two entries before the TX FIFO fills
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer_full <= 1'b0;
        end else begin
            buffer_full <= (tx_count >= BF_THRESH);
        end
    end

    assign bus.io_buffer_full = buffer_full;
`else
    logic tx_count_unused;
    assign tx_count_unused = ^tx_count;
`endif

endmodule
